// File: rtl/alu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : alu_pkg                                                 |
// | Description : Shared ALU constants: datapath width, MUL state         |
// |               encoding and the MUL opcode.                            |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  // Multiplier control states
  localparam logic [1:0] MUL_ST_IDLE = 2'd0;
  localparam logic [1:0] MUL_ST_RUN  = 2'd1;
  localparam logic [1:0] MUL_ST_DONE = 2'd2;

  // ALU opcode that selects the multiplier result
  localparam logic [3:0] ALU_OP_MUL = 4'd6;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/seq_multiplier32_adder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : seq_multiplier32_adder                                  |
// | Description : Ripple-carry adder with carry-in and carry-out, shared  |
// |               between the ALU add path and the multiplier.            |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module seq_multiplier32_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin_i;

  // One full adder per bit, carry rippling from LSB to MSB
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_p;
    assign w_p            = a_i[i] ^ b_i[i];
    assign sum_o[i]       = w_p ^ w_carry[i];
    assign w_carry[i + 1] = (a_i[i] & b_i[i]) | (w_p & w_carry[i]);
  end

  assign cout_o = w_carry[WIDTH];

endmodule : seq_multiplier32_adder
`default_nettype wire

// File: rtl/seq_multiplier32.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : seq_multiplier32                                        |
// | Description : Unsigned shift-add multiplier. One conditional add and  |
// |               one right shift per cycle; 2*WIDTH-bit exact product.   |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module seq_multiplier32
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf
);

  localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q,   state_d;
  logic [WIDTH-1:0]   mcand_q,   mcand_d;
  logic [WIDTH-1:0]   acc_hi_q,  acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q,  acc_lo_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               ovf_q,     ovf_d;
  logic               done_q,    done_d;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  // Partial product is the multiplicand when the current multiplier bit is set
  assign w_addend = acc_lo_q[0] ? mcand_q : '0;

  seq_multiplier32_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i    (acc_hi_q),
    .b_i    (w_addend),
    .cin_i  (1'b0),
    .sum_o  (w_sum),
    .cout_o (w_cout)
  );

  // Control FSM and datapath next-state; carry-out lands in acc_hi MSB so
  // the full-scale product does not lose its top bit
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      MUL_ST_IDLE: begin
        if (start) begin
          mcand_d  = in1;
          acc_hi_d = '0;
          acc_lo_d = in2;
          cnt_d    = '0;
          state_d  = MUL_ST_RUN;
        end
      end
      MUL_ST_RUN: begin
        acc_hi_d = {w_cout, w_sum[WIDTH-1:1]};
        acc_lo_d = {w_sum[0], acc_lo_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == c_LAST_STEP) begin
          product_d = {acc_hi_d, acc_lo_d};
          ovf_d     = |acc_hi_d;
          done_d    = 1'b1;
          state_d   = MUL_ST_DONE;
        end
      end
      MUL_ST_DONE: begin
        state_d = MUL_ST_IDLE;
      end
      default: begin
        state_d = MUL_ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything including product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MUL_ST_IDLE;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != MUL_ST_IDLE);
  assign done    = done_q;
  assign product = product_q;
  assign ovf     = ovf_q;

endmodule : seq_multiplier32
`default_nettype wire

// File: tb/tb_seq_multiplier32.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_seq_multiplier32                                     |
// | Description : Directed self-checking bench for seq_multiplier32.      |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_seq_multiplier32;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic        ovf;

  int errors;
  int checks;

  seq_multiplier32 #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one multiply from an idle cycle (called #1 after a rising edge)
  // and return in the done cycle; cyc counts the start cycle as 1.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] p, output logic o,
                         output int cyc, output bit busy_seen, output bit to);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    busy_seen = (busy === 1'b1);
    cyc       = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    to = (done !== 1'b1);
    p  = product;
    o  = ovf;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    #13;
    checks++;
    if ({busy, done, ovf} !== 3'b000 || product !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b ovf=%b product=%h required 0", busy, done, ovf, product);
    end
    start = 1'b1;
    in1 = 32'd4;
    in2 = 32'd4;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_holds_idle: busy=%b required 0", busy);
    end
    start = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [63:0] p; logic o; int cyc; bit bs, to;
    run_mul(32'd3, 32'd5, p, o, cyc, bs, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout: no done within 100 cycles"); end
    checks++;
    if (!bs) begin errors++; $display("FAIL basic_busy_after_start: busy not high after start edge"); end
    checks++;
    if (cyc !== 33) begin errors++; $display("FAIL basic_latency: got %0d cycles required 33", cyc); end
    checks++;
    if (p !== 64'h0000_0000_0000_000F || o !== 1'b0) begin
      errors++; $display("FAIL basic_product: got %h ovf=%b required 000000000000000f ovf=0", p, o);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_after_done: done=%b busy=%b required 0 0", done, busy);
    end
    checks++;
    if (product !== 64'h0000_0000_0000_000F) begin
      errors++; $display("FAIL basic_hold: product=%h required 000000000000000f", product);
    end
  endtask

  task automatic test_max();
    logic [63:0] p; logic o; int cyc; bit bs, to;
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, p, o, cyc, bs, to);
    checks++;
    if (to || p !== 64'hFFFF_FFFE_0000_0001 || o !== 1'b1) begin
      errors++; $display("FAIL max_operands: got %h ovf=%b to=%b required fffffffe00000001 ovf=1", p, o, to);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_and_ovf();
    logic [63:0] p; logic o; int cyc; bit bs, to;
    run_mul(32'd0, 32'h1234_5678, p, o, cyc, bs, to);
    checks++;
    if (to || p !== 64'd0 || o !== 1'b0) begin
      errors++; $display("FAIL zero_mcand: got %h ovf=%b to=%b required 0 ovf=0", p, o, to);
    end
    @(posedge clk); #1;
    run_mul(32'h8000_0000, 32'd2, p, o, cyc, bs, to);
    checks++;
    if (to || p !== 64'h0000_0001_0000_0000 || o !== 1'b1) begin
      errors++; $display("FAIL ovf_boundary: got %h ovf=%b to=%b required 0000000100000000 ovf=1", p, o, to);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    logic [63:0] p; logic o; int cyc; bit bs, to;
    in1 = 32'd100; in2 = 32'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b1; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 1'b0; in1 = 32'd0; in2 = 32'd0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (done !== 1'b1 || product !== 64'd20000 || ovf !== 1'b0) begin
      errors++; $display("FAIL ignore_run_start: done=%b product=%h ovf=%b required 1 0000000000004e20 0", done, product, ovf);
    end
    start = 1'b1; in1 = 32'd7; in2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd20000) begin
      errors++; $display("FAIL ignore_done_start: busy=%b done=%b product=%h required 0 0 0000000000004e20", busy, done, product);
    end
    run_mul(32'd11, 32'd13, p, o, cyc, bs, to);
    checks++;
    if (to || cyc !== 33 || p !== 64'd143 || o !== 1'b0) begin
      errors++; $display("FAIL start_after_busy_falls: got %h cyc=%0d to=%b required 000000000000008f cyc=33", p, cyc, to);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [63:0] p; logic o; int cyc; bit bs, to; bit seen_done;
    in1 = 32'd7; in2 = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ovf} !== 3'b000 || product !== 64'd0) begin
      errors++; $display("FAIL reset_mid_async: busy=%b done=%b ovf=%b product=%h required 0", busy, done, ovf, product);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen_done = 1'b1; end
    checks++;
    if (seen_done || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_no_done: done_seen=%b busy=%b required 0 0", seen_done, busy);
    end
    run_mul(32'd7, 32'd9, p, o, cyc, bs, to);
    checks++;
    if (to || p !== 64'd63 || o !== 1'b0) begin
      errors++; $display("FAIL reset_mid_restart: got %h ovf=%b to=%b required 000000000000003f ovf=0", p, o, to);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [63:0] p; logic o; int cyc; bit bs, to;
    logic [31:0] a, b;
    logic [63:0] exp_p;
    for (int n = 0; n < 200; n++) begin
      a = $urandom;
      b = $urandom;
      if (n == 0) a = 32'd1;
      if (n == 1) b = 32'h8000_0001;
      exp_p = 64'(a) * 64'(b);
      run_mul(a, b, p, o, cyc, bs, to);
      checks++;
      if (to || p !== exp_p || o !== (exp_p[63:32] != 32'd0)) begin
        errors++; $display("FAIL random_%0d: %h*%h got %h ovf=%b required %h", n, a, b, p, o, exp_p);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL random_single_done_%0d: done=%b required 0", n, done);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_max();
    test_zero_and_ovf();
    test_ignore_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_multiplier32
`default_nettype wire
